multi_vender: RTL and testbench
===============================

MULTI_VENDER -- requirements
Module: multi_vender

Interface
REQ-001 SHALL have parameter PRICE_N, default 6, meaning the item price in nickels (30 cents).
REQ-002 SHALL have parameter NUM_ITEMS, default 4, meaning the number of selectable products (2..16).
REQ-003 SHALL have parameter STOCK_INIT, default 8, meaning the per-item stock after reset or restock.
REQ-004 SHALL have parameter MAX_CREDIT_N, default 20, meaning the maximum credit in nickels; CREDIT_W = $clog2(MAX_CREDIT_N+1).
REQ-005 SHALL have ports, in this order:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high reset
  nickel / dime / quarter  in  1 each  coin-present strobes, one cycle per coin
  cancel  in  1  refund all credit
  sel  in  $clog2(NUM_ITEMS)  selected item
  restock  in  1  reload all stock counters
  dispense_can  out  1  one-cycle vend pulse
  can_id  out  $clog2(NUM_ITEMS)  item vended, valid with dispense_can
  dispense_quarter / dispense_dime / dispense_nickel  out  1 each  change coin, at most one per cycle
  coin_reject  out  1  coin refused this cycle
  credit  out  CREDIT_W  current credit in nickels
  busy  out  1  high in VEND and CHANGE
  sold_out  out  NUM_ITEMS  bit i high when stock[i]==0

Function
REQ-006 SHALL implement a Moore FSM with states IDLE, COLLECT, VEND, CHANGE; all outputs decode from registered state/credit/stock only.
REQ-007 SHALL value coins as nickel=1, dime=2, quarter=5 nickels; credit arithmetic in nickel units, never wrapping.
REQ-008 SHALL accept at most one coin per cycle, priority quarter > dime > nickel; lower-priority simultaneous coins are ignored without coin_reject.
REQ-009 SHALL reject (coin_reject=1 next cycle, credit unchanged) a coin that would push credit above MAX_CREDIT_N.
REQ-010 SHALL ignore coins in VEND/CHANGE and assert coin_reject for them.
REQ-011 SHALL update credit the cycle after an accepted coin; IDLE moves to COLLECT on the first accepted coin.
REQ-012 In COLLECT, SHALL move to VEND when credit >= PRICE_N and stock[sel] > 0; when stock[sel]==0, it SHALL hold in COLLECT with credit kept.
REQ-013 In VEND (exactly one cycle), SHALL drive dispense_can=1 and can_id = sel latched on entry, decrement that stock, and subtract PRICE_N; next state CHANGE if the remainder > 0, else IDLE.
REQ-014 In IDLE or COLLECT, cancel SHALL move to CHANGE, or to IDLE when credit==0; cancel beats a coin in the same cycle (coin ignored, no reject).
REQ-015 In CHANGE, SHALL each cycle assert exactly one of the largest coin <= credit (quarter, then dime, then nickel) and subtract it; when credit reaches 0, it SHALL go to IDLE.
REQ-016 SHALL honour restock only in IDLE (all stock set to STOCK_INIT); elsewhere it is ignored.
REQ-017 Latency: coin completing price at edge n -> VEND at n+1 -> first change coin at n+2.

Reset
REQ-018 On reset, SHALL set state=IDLE, credit=0, all stock=STOCK_INIT, and all dispense, coin_reject and busy outputs 0; can_id=0; sold_out=0.
REQ-019 Reset SHALL override any state including mid-VEND/CHANGE; undispensed change is discarded.

Structure
REQ-020 Package vender_pkg SHALL hold the state enum and the coin-value constants (NICKEL_N, DIME_N, QUARTER_N).
REQ-021 SHALL instantiate one sub-module vend_stock_bank holding the NUM_ITEMS counters (decrement, restock, reset, sold_out).

Verification
REQ-022 Defaults; nickel, dime, nickel, quarter, sel=0 -> credit 1,3,4,9; can pulse id 0; dime then nickel; IDLE, credit 0.
REQ-023 Quarter then nickel, sel=1 -> dispense_can id 1, no change coins, IDLE two cycles after the nickel.
REQ-024 Dime, dime, cancel -> two dime pulses on consecutive cycles, no can, credit 0.
REQ-025 STOCK_INIT=1: buy item 2 -> sold_out[2]=1; pay 30c with sel=2 -> hold COLLECT, credit 6; sel=3 -> vend id 3.
REQ-026 Quarter+dime same cycle -> credit +5 only; four quarters then nickel -> credit 20, coin_reject pulse.
REQ-027 Reset asserted during CHANGE -> next cycle all outputs 0, credit 0, stock = STOCK_INIT.

Source files
------------

// File: rtl/vender_pkg.sv
// Shared types and coin values for the multi-product vending controller.
package vender_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StVend,
      StChange
   } state_t;

   localparam int unsigned NICKEL_N  = 1;
   localparam int unsigned DIME_N    = 2;
   localparam int unsigned QUARTER_N = 5;

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with single-item decrement, bulk restock and sold-out flags.
module vend_stock_bank #(
   parameter int unsigned NUM_ITEMS  = 4,
   parameter int unsigned STOCK_INIT = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         restock,
   input  logic                         dec,
   input  logic [$clog2(NUM_ITEMS)-1:0] dec_id,
   output logic [NUM_ITEMS-1:0]         sold_out
);

   localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 1);

   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

   always_ff @(posedge clk) begin
      if (reset || restock) begin
         for (int i = 0; i < int'(NUM_ITEMS); i++) begin
            stock_q[i] <= STOCK_W'(STOCK_INIT);
         end
      end else if (dec && (stock_q[dec_id] != '0)) begin
         stock_q[dec_id] <= stock_q[dec_id] - STOCK_W'(1);
      end
   end

   always_comb begin
      sold_out = '0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
         sold_out[i] = (stock_q[i] == '0);
      end
   end

endmodule

// File: rtl/multi_vender.sv
// Multi-product vending controller: coin collection, vend, greedy change return.
module multi_vender
   import vender_pkg::*;
#(
   parameter int unsigned  PRICE_N      = 6,
   parameter int unsigned  NUM_ITEMS    = 4,
   parameter int unsigned  STOCK_INIT   = 8,
   parameter int unsigned  MAX_CREDIT_N = 20,
   localparam int unsigned CREDIT_W     = $clog2(MAX_CREDIT_N + 1),
   localparam int unsigned SEL_W        = $clog2(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 nickel,
   input  logic                 dime,
   input  logic                 quarter,
   input  logic                 cancel,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 restock,
   output logic                 dispense_can,
   output logic [SEL_W-1:0]     can_id,
   output logic                 dispense_quarter,
   output logic                 dispense_dime,
   output logic                 dispense_nickel,
   output logic                 coin_reject,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy,
   output logic [NUM_ITEMS-1:0] sold_out
);

   state_t              state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [SEL_W-1:0]    can_id_q;
   logic                coin_reject_q;

   int unsigned credit_n, coin_n, sum_n, change_n;
   logic        coin_any, coin_fits, can_buy, in_change;

   always_comb begin
      credit_n = 32'(credit_q);
      if (quarter)     coin_n = QUARTER_N;
      else if (dime)   coin_n = DIME_N;
      else if (nickel) coin_n = NICKEL_N;
      else             coin_n = 0;
      coin_any  = quarter | dime | nickel;
      sum_n     = credit_n + coin_n;
      coin_fits = (sum_n <= MAX_CREDIT_N);
      can_buy   = (32'(sel) < NUM_ITEMS) && !sold_out[sel];
      // Largest coin not exceeding the remaining credit.
      if (credit_n >= QUARTER_N)   change_n = QUARTER_N;
      else if (credit_n >= DIME_N) change_n = DIME_N;
      else                         change_n = NICKEL_N;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         can_id_q      <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         coin_reject_q <= 1'b0;
         unique case (state_q)
            StIdle, StCollect: begin
               if (cancel) begin
                  state_q <= (credit_n == 0) ? StIdle : StChange;
               end else begin
                  if (coin_any && coin_fits) credit_q <= CREDIT_W'(sum_n);
                  coin_reject_q <= coin_any && !coin_fits;
                  if ((state_q == StCollect) && (credit_n >= PRICE_N) && can_buy) begin
                     state_q  <= StVend;
                     can_id_q <= sel;
                  end else if (coin_any && coin_fits) begin
                     state_q <= StCollect;
                  end
               end
            end
            StVend: begin
               credit_q      <= CREDIT_W'(credit_n - PRICE_N);
               state_q       <= (credit_n > PRICE_N) ? StChange : StIdle;
               coin_reject_q <= coin_any;
            end
            StChange: begin
               if (credit_n <= change_n) begin
                  credit_q <= '0;
                  state_q  <= StIdle;
               end else begin
                  credit_q <= CREDIT_W'(credit_n - change_n);
               end
               coin_reject_q <= coin_any;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   vend_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk      (clk),
      .reset    (reset),
      .restock  (restock && (state_q == StIdle)),
      .dec      (state_q == StVend),
      .dec_id   (can_id_q),
      .sold_out (sold_out)
   );

   assign in_change        = (state_q == StChange) && (credit_n != 0);
   assign dispense_can     = (state_q == StVend);
   assign can_id           = can_id_q;
   assign dispense_quarter = in_change && (change_n == QUARTER_N);
   assign dispense_dime    = in_change && (change_n == DIME_N);
   assign dispense_nickel  = in_change && (change_n == NICKEL_N);
   assign coin_reject      = coin_reject_q;
   assign credit           = credit_q;
   assign busy             = (state_q == StVend) || (state_q == StChange);

endmodule

// File: tb/tb_multi_vender.sv
// Randomized scoreboard bench for multi_vender against a transaction-level purchase model.
module tb_multi_vender;

   localparam int unsigned PRICE_N      = 6;
   localparam int unsigned NUM_ITEMS    = 4;
   localparam int unsigned STOCK_INIT   = 8;
   localparam int unsigned MAX_CREDIT_N = 20;

   logic       clk = 1'b0;
   logic       reset, nickel, dime, quarter, cancel, restock;
   logic [1:0] sel, can_id;
   logic       dispense_can, dispense_quarter, dispense_dime, dispense_nickel;
   logic       coin_reject, busy;
   logic [4:0] credit;
   logic [3:0] sold_out;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected can ids, change coins (cents) and pending reject count.
   int exp_can[$];
   int exp_chg[$];
   int exp_rej = 0;

   // Reference model state.
   int m_credit;
   int m_stock[NUM_ITEMS];

   multi_vender #(
      .PRICE_N      (PRICE_N),
      .NUM_ITEMS    (NUM_ITEMS),
      .STOCK_INIT   (STOCK_INIT),
      .MAX_CREDIT_N (MAX_CREDIT_N)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .nickel           (nickel),
      .dime             (dime),
      .quarter          (quarter),
      .cancel           (cancel),
      .sel              (sel),
      .restock          (restock),
      .dispense_can     (dispense_can),
      .can_id           (can_id),
      .dispense_quarter (dispense_quarter),
      .dispense_dime    (dispense_dime),
      .dispense_nickel  (dispense_nickel),
      .coin_reject      (coin_reject),
      .credit           (credit),
      .busy             (busy),
      .sold_out         (sold_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_sold_out();
      int v = 0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) if (m_stock[i] == 0) v |= (1 << i);
      return v;
   endfunction

   task automatic push_change(input int nick);
      int cents = nick * 5;
      while (cents > 0) begin
         if (cents >= 25)      begin exp_chg.push_back(25); cents -= 25; end
         else if (cents >= 10) begin exp_chg.push_back(10); cents -= 10; end
         else                  begin exp_chg.push_back(5);  cents -= 5;  end
      end
   endtask

   task automatic model_vend();
      exp_can.push_back(int'(sel));
      m_stock[sel]--;
      push_change(m_credit - int'(PRICE_N));
      m_credit = 0;
   endtask

   // Insert one coin mask {quarter,dime,nickel}; reports whether a purchase now completes.
   task automatic buy(input int mask, output bit vended);
      int v;
      v = mask[2] ? 5 : mask[1] ? 2 : mask[0] ? 1 : 0;
      quarter = mask[2];
      dime    = mask[1];
      nickel  = mask[0];
      if (m_credit + v > int'(MAX_CREDIT_N)) exp_rej++;
      else m_credit += v;
      tick();
      quarter = 0; dime = 0; nickel = 0;
      check("credit_after_coin", int'(credit), m_credit);
      vended = 0;
      if (m_credit >= int'(PRICE_N) && m_stock[sel] > 0) begin
         model_vend();
         vended = 1;
      end
   endtask

   task automatic settle();
      repeat (8) tick();
      check("idle_busy", int'(busy), 0);
      check("idle_credit", int'(credit), m_credit);
      check("can_queue_drained", exp_can.size(), 0);
      check("change_queue_drained", exp_chg.size(), 0);
      check("rejects_seen", exp_rej, 0);
      check("sold_out", int'(sold_out), model_sold_out());
      exp_can.delete();
      exp_chg.delete();
      exp_rej = 0;
   endtask

   // Step into VEND, optionally offering a coin there (must be refused), then drain.
   task automatic finish_vend(input bit probe);
      tick();
      if (probe) begin
         quarter = 1'($urandom_range(0, 1));
         dime    = 1'($urandom_range(0, 1));
         nickel  = ~(quarter | dime);
         exp_rej++;
         tick();
         quarter = 0; dime = 0; nickel = 0;
      end
      settle();
   endtask

   task automatic do_cancel(input int mask);
      cancel  = 1;
      quarter = mask[2];
      dime    = mask[1];
      nickel  = mask[0];
      push_change(m_credit);
      m_credit = 0;
      tick();
      cancel = 0; quarter = 0; dime = 0; nickel = 0;
      settle();
   endtask

   always @(negedge clk) begin : monitor
      int v;
      if (!reset) begin
         if (dispense_can) begin
            check("vend_busy", int'(busy), 1);
            check("can_expected", int'(exp_can.size() > 0), 1);
            if (exp_can.size() > 0) check("can_id", int'(can_id), exp_can.pop_front());
         end
         if (dispense_quarter | dispense_dime | dispense_nickel) begin
            v = dispense_quarter ? 25 : dispense_dime ? 10 : 5;
            check("change_onehot",
                  int'(dispense_quarter) + int'(dispense_dime) + int'(dispense_nickel), 1);
            check("change_expected", int'(exp_chg.size() > 0), 1);
            if (exp_chg.size() > 0) check("change_coin", v, exp_chg.pop_front());
         end
         if (coin_reject) begin
            check("reject_expected", int'(exp_rej > 0), 1);
            if (exp_rej > 0) exp_rej--;
         end
      end
   end

   initial begin
      bit vended;
      int alt;
      reset = 1; nickel = 0; dime = 0; quarter = 0; cancel = 0; restock = 0; sel = 0;
      repeat (2) tick();
      check("rst_can", int'(dispense_can), 0);
      check("rst_can_id", int'(can_id), 0);
      check("rst_coins", int'({dispense_quarter, dispense_dime, dispense_nickel}), 0);
      check("rst_reject", int'(coin_reject), 0);
      check("rst_credit", int'(credit), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_sold_out", int'(sold_out), 0);
      reset = 0;
      m_credit = 0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) m_stock[i] = STOCK_INIT;

      // Nickel, dime, nickel, quarter on item 0: 45c, change dime then nickel.
      sel = 0;
      buy(1, vended); buy(2, vended); buy(1, vended); buy(4, vended);
      check("vend_at_45c", int'(vended), 1);
      finish_vend(0);

      // Exact price on item 1.
      sel = 1;
      buy(4, vended); buy(1, vended);
      check("vend_exact", int'(vended), 1);
      finish_vend(1);

      // Dime, dime, cancel (with a stray nickel that cancel overrides).
      buy(2, vended); buy(2, vended);
      do_cancel(1);

      // Quarter and dime together count as a quarter only.
      buy(6, vended);
      do_cancel(0);

      // Empty item 3, then hold in COLLECT, overflow, ignored restock, switch item.
      sel = 3;
      repeat (STOCK_INIT) begin
         buy(4, vended); buy(1, vended);
         finish_vend(0);
      end
      repeat (4) buy(4, vended);
      buy(1, vended);
      check("hold_credit_20", int'(credit), 20);
      restock = 1;
      tick();
      restock = 0;
      check("restock_ignored", int'(sold_out), model_sold_out());
      sel = 2;
      model_vend();
      finish_vend(0);
      restock = 1;
      tick();
      restock = 0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) m_stock[i] = STOCK_INIT;
      settle();

      // Reset in the middle of returning change.
      sel = 1;
      buy(4, vended); buy(4, vended);
      tick();
      tick();
      reset = 1;
      tick();
      check("midchg_rst_coins", int'({dispense_quarter, dispense_dime, dispense_nickel}), 0);
      check("midchg_rst_credit", int'(credit), 0);
      check("midchg_rst_busy", int'(busy), 0);
      check("midchg_rst_can", int'(dispense_can), 0);
      check("midchg_rst_sold_out", int'(sold_out), 0);
      reset = 0;
      exp_can.delete();
      exp_chg.delete();
      exp_rej = 0;
      m_credit = 0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) m_stock[i] = STOCK_INIT;
      settle();

      // Random purchase sessions, biased toward item 0 so it sells out.
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 14) == 0) begin
            restock = 1;
            tick();
            restock = 0;
            for (int i = 0; i < int'(NUM_ITEMS); i++) m_stock[i] = STOCK_INIT;
         end
         sel = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3));
         vended = 0;
         for (int k = $urandom_range(1, 8); k > 0 && !vended; k--) begin
            buy(int'($urandom_range(1, 7)), vended);
         end
         alt = -1;
         for (int i = 0; i < int'(NUM_ITEMS); i++) if (alt < 0 && m_stock[i] > 0) alt = i;
         if (vended) begin
            finish_vend(1'($urandom_range(0, 1)));
         end else if (m_credit >= int'(PRICE_N) && alt >= 0 && $urandom_range(0, 1) == 1) begin
            sel = 2'(alt);
            model_vend();
            finish_vend(1'($urandom_range(0, 1)));
         end else begin
            do_cancel(int'($urandom_range(0, 7)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
